// File: rtl/inst_fetch_pkg.sv
// Shared widths, queue entry layout and fetch state encodings for the fetch stage.
package inst_fetch_pkg;

  localparam int unsigned PC_W = 11;
  localparam int unsigned IR_W = 32;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [PC_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// Prefetch FIFO of {IR,PC} entries with push/pop/flush and occupancy flags.
module inst_fetch_queue
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       N_RST,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // Storage is cleared by reset so the head reads as zero until refilled.
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues sequential reads, queues returned words, and
// restarts on decoder control transfers or execute redirects.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned    DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            N_RST,
  output logic            IEN,
  output logic [PC_W-1:0] IADDR,
  input  logic [IR_W-1:0] IDATA,
  output logic [IR_W-1:0] IR,
  output logic [PC_W-1:0] PC,
  output logic            VALID,
  input  logic            STALL,
  input  logic            HALT,
  input  logic            REDIRECT,
  input  logic [PC_W-1:0] REDIRECT_PC
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_state_t    state;
  logic [PC_W-1:0] fpc;
  logic [PC_W-1:0] issue_pc;
  logic            inflight;

  logic            accept;
  logic            transfer;
  logic            flush;
  logic            push;
  logic [AW+1:0]   occupancy;
  fetch_entry_t    push_data;
  fetch_entry_t    head;
  logic [AW:0]     q_count;
  logic            q_empty;
  logic            q_full;

  assign accept    = VALID & ~STALL;
  assign transfer  = accept & HALT;
  assign flush     = REDIRECT | transfer;
  assign push      = inflight & ~flush;
  assign occupancy = (AW+2)'(q_count) + (AW+2)'(inflight);

  // Gated by N_RST so no request is visible while reset is held.
  assign IEN   = N_RST & (state == ST_RUN) & ~q_full & (occupancy < (AW+2)'(DEPTH));
  assign IADDR = fpc;

  assign push_data.ir = IDATA;
  assign push_data.pc = issue_pc;

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state    <= ST_RUN;
      fpc      <= RESET_PC;
      issue_pc <= '0;
      inflight <= 1'b0;
    end else if (REDIRECT) begin
      state    <= ST_RUN;
      fpc      <= REDIRECT_PC;
      inflight <= 1'b0;
    end else if (transfer) begin
      state    <= ST_WAIT;
      inflight <= 1'b0;
    end else begin
      inflight <= IEN;
      if (IEN) begin
        fpc      <= fpc + PC_W'(1);
        issue_pc <= fpc;
      end
    end
  end

  inst_fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .CLK       (CLK),
    .N_RST     (N_RST),
    .push      (push),
    .push_data (push_data),
    .pop       (accept),
    .flush     (flush),
    .head      (head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  assign VALID = (state == ST_RUN) & ~q_empty;
  assign IR    = head.ir;
  assign PC    = head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, streaming, stall, halt, redirect, wrap, async reset.
`timescale 1ns/1ps
module tb_inst_fetch;

  logic        CLK = 1'b0;
  logic        N_RST = 1'b0;
  logic        STALL = 1'b0;
  logic        HALT = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [10:0] REDIRECT_PC = '0;

  logic        ien,   ien2;
  logic [10:0] iaddr, iaddr2;
  logic [31:0] idata = '0, idata2 = '0;
  logic [31:0] ir,    ir2;
  logic [10:0] pc,    pc2;
  logic        valid, valid2;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  inst_fetch #(.DEPTH(4), .RESET_PC(11'h000)) dut (
    .CLK(CLK), .N_RST(N_RST), .IEN(ien), .IADDR(iaddr), .IDATA(idata),
    .IR(ir), .PC(pc), .VALID(valid), .STALL(STALL), .HALT(HALT),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC)
  );

  inst_fetch #(.DEPTH(4), .RESET_PC(11'h7FE)) dut_wrap (
    .CLK(CLK), .N_RST(N_RST), .IEN(ien2), .IADDR(iaddr2), .IDATA(idata2),
    .IR(ir2), .PC(pc2), .VALID(valid2), .STALL(1'b0), .HALT(1'b0),
    .REDIRECT(1'b0), .REDIRECT_PC(11'h000)
  );

  // Instruction memory: one-cycle read latency, data = address + 0x100.
  always @(posedge CLK) begin
    idata  <= ien  ? ({21'b0, iaddr}  + 32'h100) : 32'hDEAD_BEEF;
    idata2 <= ien2 ? ({21'b0, iaddr2} + 32'h100) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  initial begin
    cyc(); cyc();
    chk("rst_ien",   32'(ien),   32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_ir",    ir,         32'h0);
    chk("rst_pc",    32'(pc),    32'h0);

    N_RST = 1'b1;
    #1;
    chk("c0_ien",    32'(ien),    32'h1);
    chk("c0_iaddr",  32'(iaddr),  32'h000);
    chk("c0_valid",  32'(valid),  32'h0);
    chk("c0_iaddr2", 32'(iaddr2), 32'h7FE);

    cyc();
    chk("c1_valid", 32'(valid), 32'h0);
    chk("c1_iaddr", 32'(iaddr), 32'h001);

    cyc();
    chk("c2_valid", 32'(valid), 32'h1);
    chk("c2_pc",    32'(pc),    32'h000);
    chk("c2_ir",    ir,         32'h100);
    chk("c2_pc2",   32'(pc2),   32'h7FE);
    chk("c2_ir2",   ir2,        32'h8FE);

    cyc();
    chk("c3_pc",  32'(pc),  32'h001);
    chk("c3_ir",  ir,       32'h101);
    chk("c3_pc2", 32'(pc2), 32'h7FF);

    cyc();
    chk("c4_pc",  32'(pc),  32'h002);
    chk("c4_pc2", 32'(pc2), 32'h000);
    chk("c4_ir2", ir2,      32'h100);

    cyc();
    chk("c5_pc",    32'(pc),    32'h003);
    chk("c5_ir",    ir,         32'h103);
    chk("c5_pc2",   32'(pc2),   32'h001);
    chk("c5_iaddr", 32'(iaddr), 32'h005);
    STALL = 1'b1;

    cyc();
    chk("c6_pc",    32'(pc),    32'h003);
    chk("c6_ien",   32'(ien),   32'h1);
    chk("c6_iaddr", 32'(iaddr), 32'h006);

    cyc();
    chk("c7_ien", 32'(ien), 32'h0);
    chk("c7_pc",  32'(pc),  32'h003);

    cyc();
    chk("c8_ien", 32'(ien), 32'h0);

    cyc();
    chk("c9_pc", 32'(pc), 32'h003);
    chk("c9_ir", ir,      32'h103);

    cyc();
    chk("c10_pc",  32'(pc),  32'h003);
    chk("c10_ien", 32'(ien), 32'h0);
    STALL = 1'b0;

    cyc();
    chk("c11_pc",    32'(pc),    32'h004);
    chk("c11_ir",    ir,         32'h104);
    chk("c11_iaddr", 32'(iaddr), 32'h007);

    cyc();
    chk("c12_pc", 32'(pc), 32'h005);

    cyc();
    chk("c13_pc", 32'(pc), 32'h006);
    HALT = 1'b1;

    cyc();
    HALT = 1'b0;
    chk("c14_valid", 32'(valid), 32'h0);
    chk("c14_ien",   32'(ien),   32'h0);

    cyc();
    chk("c15_valid", 32'(valid), 32'h0);
    chk("c15_ien",   32'(ien),   32'h0);
    REDIRECT = 1'b1;
    REDIRECT_PC = 11'h200;

    cyc();
    REDIRECT = 1'b0;
    chk("c16_ien",   32'(ien),   32'h1);
    chk("c16_iaddr", 32'(iaddr), 32'h200);
    chk("c16_valid", 32'(valid), 32'h0);
    HALT = 1'b1;

    cyc();
    HALT = 1'b0;
    chk("c17_valid", 32'(valid), 32'h0);
    chk("c17_iaddr", 32'(iaddr), 32'h201);

    cyc();
    chk("c18_valid", 32'(valid), 32'h1);
    chk("c18_pc",    32'(pc),    32'h200);
    chk("c18_ir",    ir,         32'h300);
    STALL = 1'b1;

    cyc();
    chk("c19_iaddr", 32'(iaddr), 32'h203);
    cyc();
    chk("c20_ien", 32'(ien), 32'h0);
    cyc();
    chk("c21_ien", 32'(ien), 32'h0);
    chk("c21_pc",  32'(pc),  32'h200);
    STALL = 1'b0;
    HALT = 1'b1;
    REDIRECT = 1'b1;
    REDIRECT_PC = 11'h055;

    cyc();
    REDIRECT = 1'b0;
    HALT = 1'b0;
    chk("c22_valid", 32'(valid), 32'h0);
    chk("c22_ien",   32'(ien),   32'h1);
    chk("c22_iaddr", 32'(iaddr), 32'h055);

    cyc();
    chk("c23_valid", 32'(valid), 32'h0);
    cyc();
    chk("c24_valid", 32'(valid), 32'h1);
    chk("c24_pc",    32'(pc),    32'h055);
    chk("c24_ir",    ir,         32'h155);
    cyc();
    chk("c25_pc", 32'(pc), 32'h056);
    chk("c25_ir", ir,      32'h156);

    @(posedge CLK);
    #2;
    N_RST = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 32'h0);
    chk("arst_ien",   32'(ien),   32'h0);
    chk("arst_ir",    ir,         32'h0);
    chk("arst_pc",    32'(pc),    32'h0);

    cyc();
    N_RST = 1'b1;
    #1;
    chk("rel2_ien",   32'(ien),   32'h1);
    chk("rel2_iaddr", 32'(iaddr), 32'h000);

    cyc();
    cyc();
    chk("rel2_valid", 32'(valid), 32'h1);
    chk("rel2_pc",    32'(pc),    32'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: INST_FETCH

Interface
REQ-001 Parameter: DEPTH, 4, number of prefetch queue entries; power of two, minimum 2.
REQ-002 Parameter: RESET_PC, 11'd0, address of the first fetch after reset.
REQ-003 Port: CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: N_RST  in  1  reset, asynchronous, active-low.
REQ-005 Port: IEN  out  1  instruction memory read request.
REQ-006 Port: IADDR  out  11  instruction word address; meaningful only when IEN=1.
REQ-007 Port: IDATA  in  32  read data, valid exactly one cycle after IEN=1, no backpressure.
REQ-008 Port: IR  out  32  instruction word presented to the decoder (queue head).
REQ-009 Port: PC  out  11  address of IR.
REQ-010 Port: VALID  out  1  IR/PC hold a live instruction.
REQ-011 Port: STALL  in  1  decoder cannot accept the current IR this cycle.
REQ-012 Port: HALT  in  1  decoder accepted a control transfer/HLT, or is stopped.
REQ-013 Port: REDIRECT  in  1  one-cycle pulse from execute: restart fetch.
REQ-014 Port: REDIRECT_PC  in  11  restart address, sampled when REDIRECT=1.

Function
REQ-015 Accept = VALID & ~STALL; the queue head pops on accept; IR/PC/VALID are held unchanged while VALID & STALL.
REQ-016 Transfer = Accept & HALT; transfer flushes the queue, cancels any in-flight read, and enters state WAIT.
REQ-017 States: RUN (fetching), WAIT (IEN=0, VALID=0, awaiting REDIRECT); reset enters RUN.
REQ-018 REDIRECT in any state flushes the queue, cancels the in-flight read, loads fpc<=REDIRECT_PC, and enters RUN.
REQ-019 REDIRECT and Transfer in the same cycle: REDIRECT wins (RUN, fpc=REDIRECT_PC).
REQ-020 IEN = RUN & (count + inflight < DEPTH); IADDR = fpc; on IEN, fpc<=fpc+1 modulo 2048 (2047 wraps to 0).
REQ-021 inflight is set on IEN and cleared otherwise; it is forced to 0 by a flush in the same cycle.
REQ-022 When inflight=1 and there is no flush, {IDATA, issue address} is written to the queue tail at the end of that cycle.
REQ-023 VALID = RUN & ~empty; IR/PC = head entry; with VALID=0, IR/PC are don't-care but stable.
REQ-024 Simultaneous push and pop keeps count unchanged; the queue never overflows (guaranteed by REQ-020), and a pop on empty is impossible.
REQ-025 Latency: REDIRECT in cycle t gives IEN at t+1 and VALID=1 with PC=REDIRECT_PC at t+3.
REQ-026 Sustained throughput is 1 instruction/cycle with STALL=0 and HALT=0.
REQ-027 HALT with VALID=0 (sticky decoder stop) has no effect.

Reset
REQ-028 While N_RST=0: state=RUN, fpc=RESET_PC, queue empty, inflight=0, IEN=0, VALID=0, IR=0, PC=0.
REQ-029 First cycle after release: IEN=1 and IADDR=RESET_PC; VALID rises 2 cycles later.
REQ-030 Reset asserted mid-operation discards queue and in-flight data immediately (asynchronous).

Structure
REQ-031 The shared package holds PC width (11), IR width (32), and the RUN/WAIT encodings.
REQ-032 The queue is one sub-module, FETCH_QUEUE (DEPTH entries of {IR,PC}, push/pop/flush, count/empty/full).

Verification
REQ-033 Reset release, STALL=0, memory returns IDATA=addr+32'h100 -> PC=0,1,2,3 on consecutive cycles from cycle 2, with matching IR.
REQ-034 STALL=1 for 5 cycles while PC=3 -> PC/IR held; IEN drops once count+inflight=4; resume gives PC=4 with no loss or duplicate.
REQ-035 Accept with HALT=1 at PC=6 -> VALID=0 next cycle; IEN=0; late IDATA ignored; state WAIT.
REQ-036 In WAIT, REDIRECT=1 with REDIRECT_PC=11'h200 at cycle t -> IADDR=11'h200 at t+1, VALID/PC=11'h200 at t+3.
REQ-037 RESET_PC=11'h7FE -> PCs 7FE, 7FF, 000, 001 (wrap-around).
REQ-038 REDIRECT coinciding with Transfer and with a full queue -> queue flushed, RUN at REDIRECT_PC; N_RST pulsed mid-stream -> outputs at reset values within the same cycle.
